// File: rtl/fpmmult_seq.sv
// Sequencer for an NxN single-precision matrix multiply S = A x B in data memory.
// Walks i/j/k, reads A/B through synchronous read ports, drives an external FMA unit, writes S row-major.
module fpmmult_seq #(
    parameter int N  = 4,
    parameter int AW = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [AW-1:0] a_base_i,
    input  logic [AW-1:0] b_base_i,
    input  logic [AW-1:0] s_base_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_a_addr_o,
    output logic [AW-1:0] rd_b_addr_o,
    input  logic [31:0]   rd_a_data_i,
    input  logic [31:0]   rd_b_data_i,
    output logic          fma_valid_o,
    output logic [31:0]   fma_a_o,
    output logic [31:0]   fma_b_o,
    output logic [31:0]   fma_c_o,
    input  logic          fma_out_valid_i,
    input  logic [31:0]   fma_out_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [31:0]   wr_data_o
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MAC   = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] j_q, j_d;
    logic [CW-1:0] k_q, k_d;
    logic [31:0]   acc_q, acc_d;
    logic [AW-1:0] a_base_q, a_base_d;
    logic [AW-1:0] b_base_q, b_base_d;
    logic [AW-1:0] s_base_q, s_base_d;

    logic          cancel;
    logic [AW-1:0] n_w, i_w, j_w, k_w;

    // Abort only has meaning while a multiply is in flight.
    assign cancel = abort_i && (state_q != S_IDLE);

    assign n_w = AW'(N);
    assign i_w = AW'(i_q);
    assign j_w = AW'(j_q);
    assign k_w = AW'(k_q);

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            s_base_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            s_base_q <= s_base_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_READ;
            S_READ:  state_d = S_MAC;
            S_MAC:   state_d = S_WAIT;
            S_WAIT: begin
                if (fma_out_valid_i) begin
                    state_d = (k_q == LAST) ? S_WRITE : S_READ;
                end
            end
            S_WRITE: state_d = ((i_q == LAST) && (j_q == LAST)) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (cancel) begin
            state_d = S_IDLE;
        end
    end

    // Index counters, accumulator and latched base addresses
    always_comb begin
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        s_base_d = s_base_q;
        if (cancel) begin
            i_d   = '0;
            j_d   = '0;
            k_d   = '0;
            acc_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_base_d = a_base_i;
                        b_base_d = b_base_i;
                        s_base_d = s_base_i;
                        i_d      = '0;
                        j_d      = '0;
                        k_d      = '0;
                        acc_d    = '0;
                    end
                end
                S_WAIT: begin
                    // A result seen in any other state is stale and dropped.
                    if (fma_out_valid_i) begin
                        acc_d = fma_out_i;
                        if (k_q != LAST) begin
                            k_d = k_q + CW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        i_d = (i_q == LAST) ? '0 : i_q + CW'(1);
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are zero outside the state that owns them
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = 1'b0;
        rd_en_o     = 1'b0;
        rd_a_addr_o = '0;
        rd_b_addr_o = '0;
        fma_valid_o = 1'b0;
        fma_a_o     = '0;
        fma_b_o     = '0;
        fma_c_o     = '0;
        wr_en_o     = 1'b0;
        wr_addr_o   = '0;
        wr_data_o   = '0;
        unique case (state_q)
            S_READ: begin
                rd_en_o     = 1'b1;
                rd_a_addr_o = a_base_q + i_w * n_w + k_w;
                rd_b_addr_o = b_base_q + k_w * n_w + j_w;
            end
            S_MAC: begin
                fma_valid_o = 1'b1;
                fma_a_o     = rd_a_data_i;
                fma_b_o     = rd_b_data_i;
                fma_c_o     = acc_q;
            end
            S_WRITE: begin
                wr_en_o   = 1'b1;
                wr_addr_o = s_base_q + i_w * n_w + j_w;
                wr_data_o = acc_q;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fpmmult_seq.sv
// Self-checking bench for fpmmult_seq: memory + FMA behavioural models, queue scoreboard,
// directed runs for identity multiply, addressing, random latency, abort, reset and N=1.
module tb_fpmmult_seq;
    localparam int N  = 4;
    localparam int AW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort;
    logic [AW-1:0] a_base, b_base, s_base;
    logic          busy, done, rd_en, fma_valid, wr_en;
    logic [AW-1:0] rd_a_addr, rd_b_addr, wr_addr;
    logic [31:0]   rd_a_data = '0, rd_b_data = '0;
    logic [31:0]   fma_a, fma_b, fma_c, wr_data;
    logic          fma_out_valid = 1'b0;
    logic [31:0]   fma_out = '0;

    fpmmult_seq #(.N(N), .AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .a_base_i(a_base), .b_base_i(b_base), .s_base_i(s_base),
        .busy_o(busy), .done_o(done), .rd_en_o(rd_en),
        .rd_a_addr_o(rd_a_addr), .rd_b_addr_o(rd_b_addr),
        .rd_a_data_i(rd_a_data), .rd_b_data_i(rd_b_data),
        .fma_valid_o(fma_valid), .fma_a_o(fma_a), .fma_b_o(fma_b), .fma_c_o(fma_c),
        .fma_out_valid_i(fma_out_valid), .fma_out_i(fma_out),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
    );

    // N=1 instance
    logic          start1, abort1;
    logic [AW-1:0] a_base1, b_base1, s_base1;
    logic          busy1, done1, rd_en1, fma_valid1, wr_en1;
    logic [AW-1:0] rd_a_addr1, rd_b_addr1, wr_addr1;
    logic [31:0]   rd_a_data1 = '0, rd_b_data1 = '0;
    logic [31:0]   fma_a1, fma_b1, fma_c1, wr_data1;
    logic          fma_out_valid1 = 1'b0;
    logic [31:0]   fma_out1 = '0;

    fpmmult_seq #(.N(1), .AW(AW)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .abort_i(abort1),
        .a_base_i(a_base1), .b_base_i(b_base1), .s_base_i(s_base1),
        .busy_o(busy1), .done_o(done1), .rd_en_o(rd_en1),
        .rd_a_addr_o(rd_a_addr1), .rd_b_addr_o(rd_b_addr1),
        .rd_a_data_i(rd_a_data1), .rd_b_data_i(rd_b_data1),
        .fma_valid_o(fma_valid1), .fma_a_o(fma_a1), .fma_b_o(fma_b1), .fma_c_o(fma_c1),
        .fma_out_valid_i(fma_out_valid1), .fma_out_i(fma_out1),
        .wr_en_o(wr_en1), .wr_addr_o(wr_addr1), .wr_data_o(wr_data1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- float helpers (exact for the small values used) ----------------
    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        if (b[30:0] == 31'h0) return 0.0;
        e = int'(b[30:23]) - 127;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fma_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c);
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    // ---------------- memory and MAC models ----------------
    logic [31:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_a_data <= mem[rd_a_addr];
            rd_b_data <= mem[rd_b_addr];
        end
    end

    bit         rand_lat = 1'b0;
    int         fixed_lat = 3;
    int         lat;
    logic [3:0] mac_cnt = '0;

    always @(posedge clk) begin
        fma_out_valid <= 1'b0;
        if (fma_valid) begin
            fma_out <= fma_model(fma_a, fma_b, fma_c);
            lat = rand_lat ? int'($urandom_range(8, 1)) : fixed_lat;
            if (lat <= 1) fma_out_valid <= 1'b1;
            else mac_cnt <= 4'(lat - 1);
        end else if (mac_cnt != 4'd0) begin
            mac_cnt <= mac_cnt - 4'd1;
            if (mac_cnt == 4'd1) fma_out_valid <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rd_en1) begin
            rd_a_data1 <= (rd_a_addr1 == 14'd5) ? 32'h40000000 : 32'hBAD0BAD0;
            rd_b_data1 <= (rd_b_addr1 == 14'd9) ? 32'h40400000 : 32'hBAD0BAD0;
        end
        fma_out_valid1 <= fma_valid1;
        if (fma_valid1) fma_out1 <= fma_model(fma_a1, fma_b1, fma_c1);
    end

    // ---------------- scoreboard ----------------
    logic [AW-1:0] q_ra[$], q_rb[$], q_wa[$];
    logic [31:0]   q_fa[$], q_fb[$], q_fc[$], q_wd[$];
    int            rd_cnt, fma_cnt, wr_cnt, done_cnt;
    logic [AW-1:0] first_ra, first_rb, first_wa, last_wa;
    logic [31:0]   s_got [0:N*N-1];
    int            n1_fma = 0, n1_wr = 0;

    task automatic flush_expect();
        q_ra.delete(); q_rb.delete(); q_wa.delete();
        q_fa.delete(); q_fb.delete(); q_fc.delete(); q_wd.delete();
    endtask

    task automatic build_expect();
        logic [AW-1:0] aa, bb;
        logic [31:0]   acc;
        flush_expect();
        rd_cnt = 0; fma_cnt = 0; wr_cnt = 0; done_cnt = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 32'h0;
                for (int k = 0; k < N; k++) begin
                    aa = a_base + AW'(i * N + k);
                    bb = b_base + AW'(k * N + j);
                    q_ra.push_back(aa);
                    q_rb.push_back(bb);
                    q_fa.push_back(mem[aa]);
                    q_fb.push_back(mem[bb]);
                    q_fc.push_back(acc);
                    acc = fma_model(mem[aa], mem[bb], acc);
                end
                q_wa.push_back(s_base + AW'(i * N + j));
                q_wd.push_back(acc);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [AW-1:0] off;
        if (rd_en) begin
            if (rd_cnt == 0) begin first_ra = rd_a_addr; first_rb = rd_b_addr; end
            rd_cnt++;
            if (q_ra.size() == 0) begin
                checks++; failures++;
                $display("FAIL extra_read: got rd_en at %0h required none", rd_a_addr);
            end else begin
                chk("rd_a_addr", 64'(rd_a_addr), 64'(q_ra.pop_front()));
                chk("rd_b_addr", 64'(rd_b_addr), 64'(q_rb.pop_front()));
            end
        end
        if (fma_valid) begin
            fma_cnt++;
            if (q_fa.size() == 0) begin
                checks++; failures++;
                $display("FAIL extra_fma: got fma_valid required none");
            end else begin
                chk("fma_a", 64'(fma_a), 64'(q_fa.pop_front()));
                chk("fma_b", 64'(fma_b), 64'(q_fb.pop_front()));
                chk("fma_c", 64'(fma_c), 64'(q_fc.pop_front()));
            end
        end
        if (wr_en) begin
            if (wr_cnt == 0) first_wa = wr_addr;
            last_wa = wr_addr;
            wr_cnt++;
            $display("WR addr=%h data=%h", wr_addr, wr_data);
            off = wr_addr - s_base;
            if (int'(off) < N * N) s_got[int'(off)] = wr_data;
            if (q_wa.size() == 0) begin
                checks++; failures++;
                $display("FAIL extra_write: got wr_en at %0h required none", wr_addr);
            end else begin
                chk("wr_addr", 64'(wr_addr), 64'(q_wa.pop_front()));
                chk("wr_data", 64'(wr_data), 64'(q_wd.pop_front()));
            end
        end
        if (done) begin
            done_cnt++;
            chk("busy_in_done", 64'(busy), 64'(1));
        end
        if (!busy) chk("idle_quiet", 64'({rd_en, fma_valid, wr_en, done}), 64'(0));
        if (fma_valid1) begin
            n1_fma++;
            chk("n1_fma_a", 64'(fma_a1), 64'h40000000);
            chk("n1_fma_b", 64'(fma_b1), 64'h40400000);
            chk("n1_fma_c", 64'(fma_c1), 64'h0);
        end
        if (wr_en1) begin
            n1_wr++;
            $display("WR1 addr=%h data=%h", wr_addr1, wr_data1);
            chk("n1_wr_addr", 64'(wr_addr1), 64'd12);
            chk("n1_wr_data", 64'(wr_data1), 64'h40c00000);
        end
    end

    // ---------------- stimulus ----------------
    task automatic init_mats();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mem[a_base + AW'(i * N + j)] = (i == j) ? 32'h3f800000 : 32'h0;
                mem[b_base + AW'(i * N + j)] = r2f(real'(j));
            end
        end
    endtask

    task automatic run_mult(input bit hold, input int exp_cycles);
        int n;
        bit got;
        build_expect();
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        n = 0; got = 1'b0;
        while (n < 5000 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done) got = 1'b1;
        end
        chk("done_seen", 64'(got), 64'(1));
        if (exp_cycles > 0) chk("done_latency", 64'(n), 64'(exp_cycles));
        if (hold) begin @(posedge clk); #1; start = 1'b0; end
        repeat (4) @(posedge clk);
        #1;
        chk("busy_after", 64'(busy), 64'(0));
        chk("queues_drained", 64'(q_wa.size() + q_ra.size() + q_fa.size()), 64'(0));
        chk("rd_count", 64'(rd_cnt), 64'(64));
        chk("fma_count", 64'(fma_cnt), 64'(64));
        chk("wr_count", 64'(wr_cnt), 64'(16));
        chk("done_pulses", 64'(done_cnt), 64'(1));
    endtask

    logic [31:0] fj [4];

    initial begin
        int  n;
        bit  got;
        real tot;
        fj[0] = 32'h0; fj[1] = 32'h3f800000; fj[2] = 32'h40000000; fj[3] = 32'h40400000;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        a_base = 14'h21C; b_base = 14'h23C; s_base = 14'h22C;
        start1 = 1'b0; abort1 = 1'b0; a_base1 = 14'd5; b_base1 = 14'd9; s_base1 = 14'd12;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        for (int i = 0; i < N * N; i++) s_got[i] = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 64'({busy, done, rd_en, fma_valid, wr_en}), 64'(0));
        chk("rst_acc", 64'(fma_c), 64'(0));
        chk("rst_busy1", 64'(busy1), 64'(0));
        rst = 1'b0;
        chk("model_pin", 64'(fma_model(32'h40000000, 32'h40400000, 32'h0)), 64'h40c00000);
        init_mats();

        // identity x float(j), fixed latency 3, offset bases
        run_mult(1'b0, 336);
        chk("first_rd_a", 64'(first_ra), 64'h21C);
        chk("first_rd_b", 64'(first_rb), 64'h23C);
        chk("first_wr", 64'(first_wa), 64'h22C);
        chk("last_wr", 64'(last_wa), 64'h23B);
        chk("S23", 64'(s_got[2 * N + 3]), 64'h40400000);
        chk("S11", 64'(s_got[1 * N + 1]), 64'h3f800000);
        chk("S30", 64'(s_got[3 * N + 0]), 64'h0);
        tot = 0.0;
        for (int e = 0; e < N * N; e++) tot = tot + f2r(s_got[e]);
        chk("sum_S", 64'(r2f(tot)), 64'h41c00000);

        // random MAC latency
        rand_lat = 1'b1;
        run_mult(1'b0, -1);
        for (int e = 0; e < N * N; e++) chk("S_randlat", 64'(s_got[e]), 64'(fj[e % N]));
        rand_lat = 1'b0;

        // abort in WAIT of element (1,2)
        build_expect();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; got = 1'b0;
        while (n < 2000 && !got) begin
            @(negedge clk); #1;
            n++;
            if (fma_cnt == 25) got = 1'b1;
        end
        chk("abort_reach", 64'(got), 64'(1));
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        flush_expect();
        chk("abort_idle", 64'({busy, rd_en, fma_valid, wr_en, done}), 64'(0));
        repeat (12) @(posedge clk);
        #1;
        chk("abort_writes", 64'(wr_cnt), 64'(6));
        chk("abort_no_done", 64'(done_cnt), 64'(0));
        run_mult(1'b0, 336);
        for (int e = 0; e < N * N; e++) chk("S_after_abort", 64'(s_got[e]), 64'(fj[e % N]));

        // reset mid-run, then run with start held high
        build_expect();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        flush_expect();
        chk("rst_mid_ctrl", 64'({busy, done, rd_en, fma_valid, wr_en}), 64'(0));
        chk("rst_mid_data", 64'({rd_a_addr, rd_b_addr, wr_addr}), 64'(0));
        chk("rst_mid_ops", 64'(fma_a | fma_b | fma_c | wr_data), 64'(0));
        repeat (12) @(posedge clk);
        #1;
        run_mult(1'b1, 336);

        // N=1 instance, MAC latency 1
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0; got = 1'b0;
        while (n < 100 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done1) got = 1'b1;
        end
        chk("n1_done_seen", 64'(got), 64'(1));
        chk("n1_latency", 64'(n), 64'(4));
        repeat (3) @(posedge clk);
        #1;
        chk("n1_busy_after", 64'(busy1), 64'(0));
        chk("n1_fma_count", 64'(n1_fma), 64'(1));
        chk("n1_wr_count", 64'(n1_wr), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
